decodificador_n_sequencial: RTL and testbench

//  Registered, parametrised N→2^N one-hot decoder with valid/ready handshake on input and output.

---
 rtl/decodificador_n_sequencial.sv | 149 ++++++++++++++
 tb/tb_decodificador_n_sequencial.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_n_sequencial.sv
// Registered N->2^N one-hot decoder with valid/ready handshake, self-running SCAN mode and masked-OR output.
// Optional feature macro: DECOD_STICKY_EN (adds sticky_clr/sticky accumulation of emitted outputs).
module decodificador_n_sequencial #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sel,
  input  logic            en,
  input  logic [2**N-1:0] mask,
  input  logic            inhibit,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            scan_start,
  input  logic            scan_stop,
  input  logic            scan_loop,
  output logic [2**N-1:0] y,
  output logic            f_mask,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef DECOD_STICKY_EN
  input  logic            sticky_clr,
  output logic [2**N-1:0] sticky,
`endif
  output logic            scan_done
);

  localparam int unsigned OUTS = 2**N;
  localparam int unsigned CW   = $clog2(DWELL + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SCAN, ST_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [OUTS-1:0] r_y, w_y_nxt;
  logic            r_f_mask, w_f_mask_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic            r_scan_done, w_scan_done_nxt;
  logic [N-1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0]   r_dwell_cnt, w_dwell_cnt_nxt;

  logic            w_hs;
  logic            w_free;
  logic            w_accept;
  logic            w_dwell_ok;
  logic [OUTS-1:0] w_dec_y;
  logic [OUTS-1:0] w_scan_y;

  // Output stage is free when empty or being consumed this cycle.
  assign w_hs       = r_out_valid & out_ready;
  assign w_free     = ~r_out_valid | out_ready;
  assign in_ready   = ((r_state == ST_IDLE) | (r_state == ST_HOLD)) & w_free & ~scan_start;
  assign w_accept   = in_valid & in_ready;
  assign w_dwell_ok = (r_dwell_cnt >= CW'(DWELL));
  assign w_dec_y    = en ? (OUTS'(1) << sel) : '0;
  assign w_scan_y   = OUTS'(1) << r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_y         <= '0;
      r_f_mask    <= 1'b0;
      r_out_valid <= 1'b0;
      r_scan_done <= 1'b0;
      r_idx       <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_f_mask    <= w_f_mask_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_scan_done <= w_scan_done_nxt;
      r_idx       <= w_idx_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_y_nxt         = r_y;
    w_f_mask_nxt    = r_f_mask;
    w_out_valid_nxt = r_out_valid;
    w_scan_done_nxt = 1'b0;
    w_idx_nxt       = r_idx;
    w_dwell_cnt_nxt = r_dwell_cnt;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (scan_start) begin
          // Dwell preloaded as satisfied so the first scan beat loads once the stage frees.
          w_state_nxt     = ST_SCAN;
          w_idx_nxt       = '0;
          w_dwell_cnt_nxt = CW'(DWELL);
          if (w_hs) w_out_valid_nxt = 1'b0;
        end else if (w_accept) begin
          w_y_nxt         = w_dec_y;
          w_f_mask_nxt    = ~inhibit & (|(w_dec_y & mask));
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_HOLD;
        end else if (w_hs) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_free && w_dwell_ok) begin
          w_y_nxt         = w_scan_y;
          w_f_mask_nxt    = ~inhibit & (|(w_scan_y & mask));
          w_out_valid_nxt = 1'b1;
          w_dwell_cnt_nxt = CW'(1);
          w_idx_nxt       = N'(r_idx + N'(1));
          if ((r_idx == N'(OUTS - 1)) && !scan_loop) begin
            w_scan_done_nxt = 1'b1;
            w_state_nxt     = ST_STOP;
          end
        end else begin
          if (w_hs) w_out_valid_nxt = 1'b0;
          if (r_dwell_cnt < CW'(DWELL)) w_dwell_cnt_nxt = CW'(r_dwell_cnt + CW'(1));
        end
        if (scan_stop) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_free) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign y         = r_y;
  assign f_mask    = r_f_mask;
  assign out_valid = r_out_valid;
  assign scan_done = r_scan_done;

`ifdef DECOD_STICKY_EN
  logic [OUTS-1:0] r_sticky;

  // Accumulates every output consumed downstream; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_sticky <= '0;
    else if (sticky_clr) r_sticky <= '0;
    else if (w_hs)       r_sticky <= r_sticky | r_y;
  end

  assign sticky = r_sticky;
`endif

endmodule

// File: tb/tb_decodificador_n_sequencial.sv
// Scoreboard bench for decodificador_n_sequencial (N=2, DWELL=3): directed vectors, decoupled output monitor.
module tb_decodificador_n_sequencial;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       en;
  logic [3:0] mask;
  logic       inhibit;
  logic       in_valid;
  logic       in_ready;
  logic       scan_start;
  logic       scan_stop;
  logic       scan_loop;
  logic [3:0] y;
  logic       f_mask;
  logic       out_valid;
  logic       out_ready;
  logic       scan_done;
`ifdef DECOD_STICKY_EN
  logic       sticky_clr;
  logic [3:0] sticky;
`endif

  always #5 clk = ~clk;

  decodificador_n_sequencial #(.N(2), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .sel(sel), .en(en), .mask(mask), .inhibit(inhibit),
    .in_valid(in_valid), .in_ready(in_ready),
    .scan_start(scan_start), .scan_stop(scan_stop), .scan_loop(scan_loop),
    .y(y), .f_mask(f_mask), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DECOD_STICKY_EN
    .sticky_clr(sticky_clr), .sticky(sticky),
`endif
    .scan_done(scan_done)
  );

  typedef struct {
    logic [3:0] y;
    logic       f;
    logic       d;
    int         gap;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_hs = 0;
  logic seen    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic push(input logic [3:0] ey, input logic ef, input logic ed, input int eg, input string nm);
    exp_t e;
    e.y = ey; e.f = ef; e.d = ed; e.gap = eg; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string nm);
    int b = 0;
    while (q.size() != 0 && b < 200) begin
      @(posedge clk); #2;
      b++;
    end
    chk({nm, "_drain_timeout"}, 32'(q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      if (scan_done) seen = 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat_y", 32'(y), 32'hFFFF);
        end else begin
          e = q.pop_front();
          chk({e.nm, "_y"}, 32'(y), 32'(e.y));
          chk({e.nm, "_f_mask"}, 32'(f_mask), 32'(e.f));
          chk({e.nm, "_scan_done"}, 32'(seen), 32'(e.d));
          if (e.gap != 0) chk({e.nm, "_gap"}, 32'(cyc - last_hs), 32'(e.gap));
        end
        seen    = 1'b0;
        last_hs = cyc;
      end
    end
  endtask

  initial begin
    logic [3:0] onehot [4];
    logic       f0101  [4];
    int         b;
    onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    f0101  = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; sel = '0; en = 1'b0; mask = '0; inhibit = 1'b0; in_valid = 1'b0;
    scan_start = 1'b0; scan_stop = 1'b0; scan_loop = 1'b0; out_ready = 1'b0;
`ifdef DECOD_STICKY_EN
    sticky_clr = 1'b0;
`endif
    fork
      monitor();
    join_none

    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_scan_done", 32'(scan_done), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    step(1);

    // Full-rate decode, mask 0101, with and without inhibit
    out_ready = 1'b1;
    for (int inh = 0; inh < 2; inh++) begin
      for (int s = 0; s < 4; s++) begin
        in_valid = 1'b1; sel = 2'(s); en = 1'b1; mask = 4'b0101; inhibit = 1'(inh);
        push(onehot[s], (inh == 0) ? f0101[s] : 1'b0, 1'b0, 0, (inh == 0) ? "dec" : "dec_inh");
        step(1);
      end
    end
    in_valid = 1'b0; inhibit = 1'b0;
    wait_empty("decode");

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd2; en = 1'b1; mask = 4'b0100;
    push(4'b0100, 1'b1, 1'b0, 0, "bp_first");
    step(1);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_y_loaded", 32'(y), 32'b0100);
    sel = 2'd3;
    push(4'b1000, 1'b0, 1'b0, 0, "bp_second");
    step(3);
    chk("bp_y_held", 32'(y), 32'b0100);
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step(1);
    chk("bp_second_loaded", 32'(y), 32'b1000);
    en = 1'b0; sel = 2'd1;
    push(4'b0000, 1'b0, 1'b0, 0, "en_off");
    step(1);
    in_valid = 1'b0;
    chk("en_off_y", 32'(y), 32'd0);
    chk("en_off_valid", 32'(out_valid), 32'd1);
    wait_empty("backpressure");
    step(2);
    chk("idle_after_bp_valid", 32'(out_valid), 32'd0);

    // SCAN one-shot, DWELL=3
    mask = 4'b0101; scan_loop = 1'b0;
    for (int s = 0; s < 4; s++) push(onehot[s], f0101[s], (s == 3), (s == 0) ? 0 : 3, "scan");
    scan_start = 1'b1;
    step(1);
    scan_start = 1'b0;
    wait_empty("scan_oneshot");
    step(4);
    chk("scan_end_in_ready", 32'(in_ready), 32'd1);
    chk("scan_end_valid", 32'(out_valid), 32'd0);

    // SCAN loop: 1000 wraps to 0001, no scan_done
    scan_loop = 1'b1;
    for (int s = 0; s < 5; s++) push(onehot[s % 4], f0101[s % 4], 1'b0, (s == 0) ? 0 : 3, "scan_loop");
    scan_start = 1'b1;
    step(1);
    scan_start = 1'b0;
    wait_empty("scan_loop");
    scan_stop = 1'b1;
    step(1);
    scan_stop = 1'b0; scan_loop = 1'b0;
    step(4);
    chk("loop_stop_valid", 32'(out_valid), 32'd0);
    chk("loop_stop_in_ready", 32'(in_ready), 32'd1);

    // scan_start beats simultaneous in_valid; stop during held beat
    in_valid = 1'b1; sel = 2'd3; en = 1'b1; scan_start = 1'b1;
    #1;
    chk("start_blocks_in_ready", 32'(in_ready), 32'd0);
    push(4'b0001, 1'b1, 1'b0, 0, "stop_first");
    step(1);
    in_valid = 1'b0; scan_start = 1'b0;
    wait_empty("stop_first");
    out_ready = 1'b0;
    b = 0;
    while (!(out_valid && y == 4'b0010) && b < 20) begin
      @(posedge clk); #2;
      b++;
    end
    chk("stop_beat_seen", 32'(out_valid && y == 4'b0010), 32'd1);
    scan_stop = 1'b1;
    push(4'b0010, 1'b0, 1'b0, 0, "stop_held");
    step(1);
    scan_stop = 1'b0;
    step(3);
    chk("stop_y_held", 32'(y), 32'b0010);
    chk("stop_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_empty("stop_held");
    step(6);
    chk("stop_idle_valid", 32'(out_valid), 32'd0);
    chk("stop_idle_in_ready", 32'(in_ready), 32'd1);

`ifdef DECOD_STICKY_EN
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    in_valid = 1'b1; en = 1'b1; mask = 4'b0000;
    sel = 2'd1; push(4'b0010, 1'b0, 1'b0, 0, "sticky_a"); step(1);
    sel = 2'd3; push(4'b1000, 1'b0, 1'b0, 0, "sticky_b"); step(1);
    in_valid = 1'b0;
    wait_empty("sticky");
    chk("sticky_accum", 32'(sticky), 32'b1010);
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd0; push(4'b0001, 1'b0, 1'b0, 0, "sticky_c");
    step(1);
    in_valid = 1'b0; sticky_clr = 1'b1; out_ready = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    chk("sticky_clear_wins", 32'(sticky), 32'd0);
    wait_empty("sticky_clr");
`endif

    // Asynchronous reset in the middle of SCAN
    out_ready = 1'b0; scan_loop = 1'b1; scan_start = 1'b1;
    step(1);
    scan_start = 1'b0;
    b = 0;
    while (!out_valid && b < 20) begin
      @(posedge clk); #2;
      b++;
    end
    chk("midscan_beat_present", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_y", 32'(y), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_scan_done", 32'(scan_done), 32'd0);
    step(2);
    rst = 1'b0; scan_loop = 1'b0;
    step(4);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_no_scan", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
